pc_redirect_ctrl: RTL and testbench

Fetch-PC sequencer for the femtoRV32 pipeline. It owns the program counter, consumes the branch/jump decision produced in EX, and redirects fetch on a taken branch or jump. After a redirect it holds a pipeline flush for a configurable number of cycles, and it halts on a misaligned target. It sits between the EX-stage branch decision logic and the IF stage.

---
 rtl/pc_redirect_ctrl.sv | 122 ++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch-PC sequencer. Owns the PC, applies EX-stage branch/jump
// redirects, holds a pipeline flush for FLUSH_CYCLES unstalled cycles afterwards
// and halts on a misaligned redirect target.
// Optional feature macro: PC_REDIRECT_PERF_CNT_EN enables the redirect and
// flush-cycle performance counters; without it both counter ports read 0.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        should_jump,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic        flush,
    output logic        trap,
    output logic [31:0] bad_addr,
    output logic [31:0] redirect_cnt,
    output logic [31:0] flush_cyc_cnt
);

    typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

    // Counter reload value; FLUSH_CYCLES is limited to 1..3 so it fits 2 bits.
    localparam logic [1:0] CntReload = 2'(FLUSH_CYCLES - 1);

    state_e      r_state;
    logic [1:0]  r_cnt;
    logic [31:0] r_pc;
    logic [31:0] r_bad_addr;

    logic        w_redirect;
    logic        w_misaligned;
    logic        w_accept;
    logic        w_trap_take;
    logic        w_flush_step;

    // Redirect qualification; EX contents are only trusted while in RUN.
    always_comb begin
        w_redirect   = (r_state == StRun) && ex_valid && should_jump && !stall;
        w_misaligned = (target[1:0] != 2'b00);
        w_accept     = w_redirect && !w_misaligned;
        w_trap_take  = w_redirect && w_misaligned;
        w_flush_step = (r_state == StFlush) && !stall;
    end

    // State, PC, flush counter and trap address; stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StRun;
            r_cnt      <= 2'd0;
            r_pc       <= RESET_PC;
            r_bad_addr <= 32'h0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_trap_take) begin
                        r_state    <= StHalt;
                        r_bad_addr <= target;
                    end else if (w_accept) begin
                        r_state <= StFlush;
                        r_pc    <= target;
                        r_cnt   <= CntReload;
                    end else if (!stall) begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                StFlush: begin
                    if (w_flush_step) begin
                        r_pc <= r_pc + 32'd4;
                        if (r_cnt == 2'd0) begin
                            r_state <= StRun;
                        end else begin
                            r_cnt <= r_cnt - 2'd1;
                        end
                    end
                end
                StHalt: begin
                    // Only rst leaves HALT.
                end
                default: r_state <= StRun;
            endcase
        end
    end

    // Outputs are the PC register and state decodes.
    always_comb begin
        pc       = r_pc;
        bad_addr = r_bad_addr;
        flush    = (r_state == StFlush);
        trap     = (r_state == StHalt);
    end

`ifdef PC_REDIRECT_PERF_CNT_EN
    logic [31:0] r_redirect_cnt;
    logic [31:0] r_flush_cyc_cnt;

    // Performance counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_cnt  <= 32'h0;
            r_flush_cyc_cnt <= 32'h0;
        end else begin
            if (w_accept) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
            if (w_flush_step) begin
                r_flush_cyc_cnt <= r_flush_cyc_cnt + 32'd1;
            end
        end
    end

    assign redirect_cnt  = r_redirect_cnt;
    assign flush_cyc_cnt = r_flush_cyc_cnt;
`else
    assign redirect_cnt  = 32'h0;
    assign flush_cyc_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed-vector bench for pc_redirect_ctrl with
// hand-computed expectations. Counter expectations follow PC_REDIRECT_PERF_CNT_EN.
module tb_pc_redirect_ctrl;

`ifdef PC_REDIRECT_PERF_CNT_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic        should_jump;
    logic [31:0] target;
    logic [31:0] pc;
    logic        flush;
    logic        trap;
    logic [31:0] bad_addr;
    logic [31:0] redirect_cnt;
    logic [31:0] flush_cyc_cnt;

    int n_cmp;
    int n_err;

    pc_redirect_ctrl #(
        .RESET_PC     (32'h0000_0000),
        .FLUSH_CYCLES (2)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .should_jump   (should_jump),
        .target        (target),
        .pc            (pc),
        .flush         (flush),
        .trap          (trap),
        .bad_addr      (bad_addr),
        .redirect_cnt  (redirect_cnt),
        .flush_cyc_cnt (flush_cyc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pf(input string tag, input logic [31:0] exp_pc, input logic exp_fl);
        check({tag, ".pc"}, pc, exp_pc);
        check({tag, ".flush"}, {31'h0, flush}, {31'h0, exp_fl});
    endtask

    function automatic logic [31:0] pc_exp(input int n);
        return Perf ? 32'(n) : 32'h0;
    endfunction

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        ex_valid    = 1'b0;
        should_jump = 1'b0;
        target      = 32'h0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk_pf("rst", 32'h0, 1'b0);
        check("rst.trap", {31'h0, trap}, 32'h0);
        check("rst.bad", bad_addr, 32'h0);
        check("rst.rcnt", redirect_cnt, 32'h0);
        check("rst.fcnt", flush_cyc_cnt, 32'h0);

        // Sequential fetch 0,4,8,12,16
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_pf($sformatf("seq%0d", i), 32'(4 * i), 1'b0);
        end

        // Redirect to 0x100 from pc 0x10
        ex_valid    = 1'b1;
        should_jump = 1'b1;
        target      = 32'h100;
        tick();
        ex_valid    = 1'b0;
        should_jump = 1'b0;
        chk_pf("jmp0", 32'h100, 1'b1);
        tick();
        chk_pf("jmp1", 32'h104, 1'b1);
        tick();
        chk_pf("jmp2", 32'h108, 1'b0);
        check("jmp.rcnt", redirect_cnt, pc_exp(1));
        check("jmp.fcnt", flush_cyc_cnt, pc_exp(2));

        // Redirect held off by a 3-cycle stall, then a stall mid-FLUSH
        stall       = 1'b1;
        ex_valid    = 1'b1;
        should_jump = 1'b1;
        target      = 32'h200;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_pf($sformatf("stl%0d", i), 32'h108, 1'b0);
        end
        check("stl.rcnt", redirect_cnt, pc_exp(1));
        stall = 1'b0;
        tick();
        ex_valid    = 1'b0;
        should_jump = 1'b0;
        chk_pf("stjmp", 32'h200, 1'b1);
        stall = 1'b1;
        tick();
        chk_pf("fstl0", 32'h200, 1'b1);
        tick();
        chk_pf("fstl1", 32'h200, 1'b1);
        check("fstl.fcnt", flush_cyc_cnt, pc_exp(2));
        stall = 1'b0;
        tick();
        chk_pf("fst2", 32'h204, 1'b1);
        tick();
        chk_pf("fst3", 32'h208, 1'b0);
        check("fst.rcnt", redirect_cnt, pc_exp(2));
        check("fst.fcnt", flush_cyc_cnt, pc_exp(4));

        // Redirect near the top, jump request during FLUSH ignored, PC wrap
        ex_valid    = 1'b1;
        should_jump = 1'b1;
        target      = 32'hFFFF_FFF0;
        tick();
        chk_pf("hi0", 32'hFFFF_FFF0, 1'b1);
        target = 32'h300;
        tick();
        chk_pf("hi1", 32'hFFFF_FFF4, 1'b1);
        tick();
        ex_valid    = 1'b0;
        should_jump = 1'b0;
        chk_pf("hi2", 32'hFFFF_FFF8, 1'b0);
        check("hi.rcnt", redirect_cnt, pc_exp(3));
        tick();
        chk_pf("wrap0", 32'hFFFF_FFFC, 1'b0);
        tick();
        chk_pf("wrap1", 32'h0, 1'b0);
        tick();
        chk_pf("wrap2", 32'h4, 1'b0);
        check("wrap.fcnt", flush_cyc_cnt, pc_exp(6));

        // Misaligned redirect traps; later redirects ignored
        ex_valid    = 1'b1;
        should_jump = 1'b1;
        target      = 32'h202;
        tick();
        target = 32'h400;
        chk_pf("trap0", 32'h4, 1'b0);
        check("trap0.trap", {31'h0, trap}, 32'h1);
        check("trap0.bad", bad_addr, 32'h202);
        tick();
        tick();
        ex_valid    = 1'b0;
        should_jump = 1'b0;
        chk_pf("trap1", 32'h4, 1'b0);
        check("trap1.trap", {31'h0, trap}, 32'h1);
        check("trap1.bad", bad_addr, 32'h202);
        check("trap1.rcnt", redirect_cnt, pc_exp(3));

        // Reset from HALT, with stall high to confirm rst wins
        rst   = 1'b1;
        stall = 1'b1;
        tick();
        rst   = 1'b0;
        stall = 1'b0;
        chk_pf("hrst", 32'h0, 1'b0);
        check("hrst.trap", {31'h0, trap}, 32'h0);
        check("hrst.bad", bad_addr, 32'h0);
        check("hrst.rcnt", redirect_cnt, 32'h0);
        check("hrst.fcnt", flush_cyc_cnt, 32'h0);

        // Reset mid-FLUSH returns to RUN
        ex_valid    = 1'b1;
        should_jump = 1'b1;
        target      = 32'h500;
        tick();
        ex_valid    = 1'b0;
        should_jump = 1'b0;
        chk_pf("mf0", 32'h500, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_pf("mfrst", 32'h0, 1'b0);
        tick();
        chk_pf("mfrun", 32'h4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
